// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// Optional macro SERIAL_SUB_ADD_MODE_EN adds the 1-bit 'mode' signal (0 = subtract, 1 = add).
// master: the requester that drives start and the operands.
// slave: the arithmetic unit that returns status and result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             mode;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

`ifdef SERIAL_SUB_ADD_MODE_EN
    modport master (
        output start, a, b, mode,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, mode,
        output busy, done, diff, borrow_out
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), LSB first, one bit per clock.
// borrow_out is 1 iff a < b (unsigned).
// The start strobe is sampled only in IDLE.
// The result and final borrow update on entry to DONE and are held until the next DONE.
// Optional macro SERIAL_SUB_ADD_MODE_EN adds a captured mode bit.
// With mode = 1 the unit adds, and borrow_out reports the carry-out instead.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             mode_q, mode_d;
`endif

    // Cell inputs and outputs for the current bit position.
    logic x_bit, y_bit, d_bit, br_next;
    logic [WIDTH-1:0] res_shifted;

    // Single-bit subtractor cell (full adder in add mode) on the operand LSBs.
    always_comb begin
        x_bit = opa_q[0];
        y_bit = opb_q[0];
        d_bit = x_bit ^ y_bit ^ br_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (mode_q) begin
            br_next = (x_bit & y_bit) | (br_q & (x_bit ^ y_bit));
        end else begin
            br_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
        end
`else
        br_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
`endif
        // The new bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
        res_shifted = {d_bit, res_q[WIDTH-1:1]};
    end

    // Next-state and datapath update; every register holds unless its state moves it.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        mode_d  = mode_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    mode_d  = bus.mode;
`endif
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                res_d = res_shifted;
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Publish directly from the final cell output.
                    // diff then changes exactly on entry to DONE, not one cycle later.
                    diff_d  = res_shifted;
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so an abort drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    // Status is decoded from the state register, so it is glitch-free and zero in reset.
    always_comb begin
        bus.busy       = (state_q == SHIFT);
        bus.done       = (state_q == DONE);
        bus.diff       = diff_q;
        bus.borrow_out = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// The behavioural reference is plain modular arithmetic.
// Honours SERIAL_SUB_ADD_MODE_EN when it is defined.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;

    int unsigned compared;
    int unsigned mismatched;

    logic [WIDTH-1:0] last_diff;
    logic             last_bout;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned arithmetic modulo 2^WIDTH, returns {borrow_or_carry, result}.
    function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic md);
        logic [WIDTH:0] full;
        if (md) begin
            full = {1'b0, x} + {1'b0, y};
            return full;
        end
        full = {1'b0, x} - {1'b0, y};
        return {(x < y), full[WIDTH-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_mode(input logic md);
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.mode = md;
`else
        if (md) $error("FAIL drive_mode: observed add request expected subtract-only build");
`endif
    endtask

    // One full operation.
    // If rk != 0, start is re-pulsed with (ra, rb) during busy cycle rk.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] opa,
                         input logic [WIDTH-1:0] opb, input logic md,
                         input int unsigned rk, input logic [WIDTH-1:0] ra,
                         input logic [WIDTH-1:0] rb);
        logic [WIDTH:0]   exp;
        int unsigned      busy_cnt;
        int unsigned      done_cnt;
        int unsigned      done_k;
        logic             held;
        logic [WIDTH-1:0] got_diff;
        logic             got_bout;

        exp      = ref_model(opa, opb, md);
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = 0;
        held     = 1'b1;
        got_diff = 'x;
        got_bout = 1'bx;

        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = opa;
        bus.b     = opb;
        drive_mode(md);

        for (int unsigned k = 1; k <= WIDTH + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
            end
            if (rk != 0 && k == rk) begin
                bus.start = 1'b1;
                bus.a     = ra;
                bus.b     = rb;
            end
            if (rk != 0 && k == rk + 1) bus.start = 1'b0;

            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (bus.diff !== last_diff || bus.borrow_out !== last_bout) held = 1'b0;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k   = k;
                    got_diff = bus.diff;
                    got_bout = bus.borrow_out;
                end
            end
        end

        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " done_latency"}, done_k, WIDTH + 1);
        check({tag, " busy_cycles"}, busy_cnt, WIDTH);
        check({tag, " hold_in_shift"}, 32'(held), 1);
        check({tag, " diff"}, 32'(got_diff), 32'(exp[WIDTH-1:0]));
        check({tag, " borrow_out"}, 32'(got_bout), 32'(exp[WIDTH]));
        check({tag, " diff_after"}, 32'(bus.diff), 32'(exp[WIDTH-1:0]));
        last_diff = exp[WIDTH-1:0];
        last_bout = exp[WIDTH];
    endtask

    initial begin
        int unsigned stray_done;
        logic [WIDTH-1:0] ra, rb;
        logic rm;

        compared   = 0;
        mismatched = 0;
        last_diff  = '0;
        last_bout  = 1'b0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        drive_mode(1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst busy", 32'(bus.busy), 0);
        check("rst done", 32'(bus.done), 0);
        check("rst diff", 32'(bus.diff), 0);
        check("rst borrow", 32'(bus.borrow_out), 0);
        rst_n = 1'b1;

        // Directed subtractions.
        do_op("5-3", 8'd5, 8'd3, 1'b0, 0, '0, '0);
        do_op("3-5", 8'd3, 8'd5, 1'b0, 0, '0, '0);
        do_op("0-1", 8'h00, 8'h01, 1'b0, 0, '0, '0);

        // Outputs hold through idle cycles.
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle hold diff", 32'(bus.diff), 32'hFF);
            check("idle hold borrow", 32'(bus.borrow_out), 1);
            check("idle done", 32'(bus.done), 0);
        end

        do_op("FF-FF", 8'hFF, 8'hFF, 1'b0, 0, '0, '0);
        do_op("00-00", 8'h00, 8'h00, 1'b0, 0, '0, '0);

        // Start re-pulsed mid-operation must be ignored.
        do_op("20-7 repulse", 8'd20, 8'd7, 1'b0, 3, 8'd9, 8'd1);

        // Abort by reset during busy cycle 4.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd37;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy_before", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus.busy), 0);
        check("abort done", 32'(bus.done), 0);
        check("abort diff", 32'(bus.diff), 0);
        check("abort borrow", 32'(bus.borrow_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray_done = 0;
        for (int unsigned i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) stray_done++;
        end
        check("abort no_activity", stray_done, 0);
        last_diff = '0;
        last_bout = 1'b0;
        do_op("after abort 5-3", 8'd5, 8'd3, 1'b0, 0, '0, '0);

`ifdef SERIAL_SUB_ADD_MODE_EN
        do_op("add FF+01", 8'hFF, 8'h01, 1'b1, 0, '0, '0);
        do_op("sub FF-01", 8'hFF, 8'h01, 1'b0, 0, '0, '0);
`endif

        // Randomised operands against the reference model.
        for (int unsigned i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
`ifdef SERIAL_SUB_ADD_MODE_EN
            rm = 1'($urandom);
`else
            rm = 1'b0;
`endif
            do_op("random", ra, rb, rm, 0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
